prbs_checker: RTL and testbench

Serial pseudo-random bit sequence (PRBS) checker. It is the receive-side counterpart of the team's Fibonacci LFSR generator. It takes the generator's serial feedback-bit stream, self-synchronises by capturing N consecutive bits, then free-runs a local reference LFSR. Every subsequent received bit is compared against the reference; mismatches are counted, and lock is declared lost after a run of consecutive errors. It sits at the end of link/BIST paths that the LFSR generator drives.

---
 rtl/prbs_checker.sv | 100 ++++++++++
 tb/tb_prbs_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises on N valid bits, then free-runs a reference LFSR and counts mismatches.
// Latency: bit_err/err_count/locked update on the edge sampling the bit, visible the next cycle.
// Backpressure: none; bit_valid=0 simply holds all state, the checker always accepts a sampled bit.
module prbs_checker #(
    parameter int N           = 4,
    parameter int CNT_W       = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_count,
    output logic [N-1:0]     ref_state
);

    typedef enum logic {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Feedback tap masks matching the Fibonacci generator, over an 8-bit view of the register.
    localparam logic [7:0] TAPS = (N == 5) ? 8'h14 :
                                  (N == 8) ? 8'hB8 :
                                             8'(8'h3 << (N - 2));

    state_t         state;
    logic [N-1:0]   shadow;
    logic [3:0]     sync_cnt;
    logic [3:0]     miss_run;

    logic [7:0]     shadow_ext;
    logic           pred;
    logic           mismatch;
    logic [N-1:0]   shift_in;
    logic [N-1:0]   shift_pred;

    assign shadow_ext = 8'(shadow);
    assign pred       = ^(shadow_ext & TAPS);
    assign mismatch   = bit_in ^ pred;
    assign shift_in   = {shadow[N-2:0], bit_in};
    assign shift_pred = {shadow[N-2:0], pred};

    assign locked    = (state == LOCKED);
    assign ref_state = shadow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SYNC;
            shadow    <= '0;
            sync_cnt  <= '0;
            miss_run  <= '0;
            bit_err   <= 1'b0;
            err_count <= '0;
        end else begin
            bit_err <= 1'b0;
            if (bit_valid) begin
                case (state)
                    SYNC: begin
                        shadow <= shift_in;
                        if (sync_cnt == 4'(N - 1)) begin
                            // An all-zero capture is the LFSR lockup state; restart capture.
                            sync_cnt <= '0;
                            if (shift_in != '0)
                                state <= LOCKED;
                        end else begin
                            sync_cnt <= sync_cnt + 4'd1;
                        end
                    end
                    LOCKED: begin
                        // Reference free-runs on its own prediction, so one bad bit is one error.
                        shadow <= shift_pred;
                        if (mismatch) begin
                            bit_err <= 1'b1;
                            if (!(&err_count))
                                err_count <= err_count + 1'b1;
                            if (miss_run == 4'(LOSS_THRESH - 1)) begin
                                state    <= SYNC;
                                shadow   <= '0;
                                sync_cnt <= '0;
                                miss_run <= '0;
                            end else begin
                                miss_run <= miss_run + 4'd1;
                            end
                        end else begin
                            miss_run <= '0;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
            if (clear_cnt)
                err_count <= '0;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker (N=4): vector table for the gapped lock, scripted corner cases, then random traffic vs a queue model.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked_a, bit_err_a, locked_b, bit_err_b;
    logic [15:0] err_count_a;
    logic [1:0]  err_count_b;
    logic [3:0]  ref_state_a, ref_state_b;

    prbs_checker #(.N(4), .CNT_W(16), .LOSS_THRESH(4)) dut_a (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear_cnt(clear_cnt),
        .locked(locked_a), .bit_err(bit_err_a), .err_count(err_count_a), .ref_state(ref_state_a));

    prbs_checker #(.N(4), .CNT_W(2), .LOSS_THRESH(4)) dut_b (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear_cnt(clear_cnt),
        .locked(locked_b), .bit_err(bit_err_b), .err_count(err_count_b), .ref_state(ref_state_b));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Generator output for seed 0001, first bit at the MSB of the literal.
    logic [14:0] pat = 15'b001101011110001;
    int pos = 0;

    // Reference model: recent reference bits kept oldest-first; prediction is the recurrence
    // x[n] = x[n-4] ^ x[n-3] of the x^4+x^3+1 sequence.
    int  q[$];
    bit  m_locked, m_err;
    int  m_cnt_a, m_cnt_b, m_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pbit(input int p);
        return pat[14 - (p % 15)];
    endfunction

    function automatic int m_ref();
        int r = 0;
        foreach (q[i]) r = (r << 1) | q[i];
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_locked = 0; m_err = 0; m_cnt_a = 0; m_cnt_b = 0; m_miss = 0;
    endtask

    task automatic model_step(input logic b, input logic v, input logic c);
        int sum;
        int p;
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                q.push_back(int'(b));
                if (q.size() == 4) begin
                    sum = 0;
                    foreach (q[i]) sum += q[i];
                    if (sum != 0) m_locked = 1;
                    else q.delete();
                end
            end else begin
                p = q[0] ^ q[1];
                void'(q.pop_front());
                q.push_back(p);
                if (int'(b) != p) begin
                    m_err = 1;
                    m_cnt_a = (m_cnt_a < 65535) ? m_cnt_a + 1 : 65535;
                    m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
                    m_miss++;
                    if (m_miss == 4) begin
                        m_locked = 0;
                        q.delete();
                        m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end
    endtask

    // Drive one cycle, then compare both DUTs against the model one step after the edge.
    task automatic step(input logic b, input logic v, input logic c);
        bit_in = b; bit_valid = v; clear_cnt = c;
        @(posedge clk);
        #1;
        model_step(b, v, c);
        chk("locked", locked_a, m_locked);
        chk("bit_err", bit_err_a, m_err);
        chk("err_count", err_count_a, m_cnt_a);
        chk("ref_state", ref_state_a, m_ref());
        chk("err_count_sat", err_count_b, m_cnt_b);
    endtask

    task automatic good();
        step(pbit(pos), 1'b1, 1'b0);
        pos++;
    endtask

    task automatic bad(input logic c);
        step(~pbit(pos), 1'b1, c);
        pos++;
    endtask

    task automatic do_reset();
        bit_valid = 1'b0; clear_cnt = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        pos = 0;
        #1;
    endtask

    typedef struct {
        logic       b, v, c;
        logic       lk, er;
        logic [15:0] cnt;
        logic [3:0] rs;
    } vec_t;

    vec_t tbl[13];
    bit   seen_lock;

    initial begin
        // Gapped lock: valid toggles, invalid cycles carry a 1 that must be ignored.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 4'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 4'd3};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 4'd3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 4'd6};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 4'd13};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 4'd10};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 4'd10};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 4'd5};

        // Reset state
        model_reset();
        #12;
        chk("rst_locked", locked_a, 0);
        chk("rst_bit_err", bit_err_a, 0);
        chk("rst_err_count", err_count_a, 0);
        chk("rst_ref_state", ref_state_a, 0);
        #1 reset = 1'b1;
        #3;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].b, tbl[i].v, tbl[i].c);
            chk($sformatf("tbl%0d_locked", i), locked_a, tbl[i].lk);
            chk($sformatf("tbl%0d_bit_err", i), bit_err_a, tbl[i].er);
            chk($sformatf("tbl%0d_err_count", i), err_count_a, tbl[i].cnt);
            chk($sformatf("tbl%0d_ref_state", i), ref_state_a, tbl[i].rs);
        end

        // Lock acquisition over 100 clean bits
        do_reset();
        for (int i = 0; i < 100; i++) begin
            good();
            if (i == 2) chk("lock_before_4th", locked_a, 0);
            if (i == 3) begin
                chk("lock_at_4th", locked_a, 1);
                chk("ref_at_4th", ref_state_a, 4'b0011);
            end
        end
        chk("clean_err_count", err_count_a, 0);

        // Single-bit error
        bad(1'b0);
        chk("single_bit_err", bit_err_a, 1);
        chk("single_err_count", err_count_a, 1);
        chk("single_locked", locked_a, 1);
        good();
        chk("after_single_no_err", bit_err_a, 0);

        // Loss of lock after 4 consecutive errors, then relock
        for (int i = 0; i < 4; i++) begin
            bad(1'b0);
            chk("loss_locked", locked_a, (i < 3) ? 1 : 0);
        end
        chk("loss_err_count", err_count_a, 5);
        for (int i = 0; i < 4; i++) begin
            good();
            chk("relock", locked_a, (i == 3) ? 1 : 0);
        end
        chk("relock_err_count", err_count_a, 5);

        // All-zero input
        do_reset();
        seen_lock = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (locked_a) seen_lock = 1;
        end
        chk("zero_never_locked", seen_lock, 0);
        chk("zero_err_count", err_count_a, 0);

        // Saturation (CNT_W=2) and clear coinciding with an error
        do_reset();
        for (int i = 0; i < 4; i++) good();
        for (int i = 0; i < 5; i++) begin
            bad(1'b0);
            good();
            good();
        end
        chk("sat_count", err_count_b, 3);
        chk("sat_wide_count", err_count_a, 5);
        bad(1'b1);
        chk("clear_bit_err", bit_err_b, 1);
        chk("clear_count", err_count_b, 0);
        chk("clear_wide_count", err_count_a, 0);
        chk("clear_locked", locked_b, 1);

        // Reset asserted mid-stream clears outputs immediately
        for (int i = 0; i < 7; i++) good();
        bad(1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_locked", locked_a, 0);
        chk("midrst_bit_err", bit_err_a, 0);
        chk("midrst_err_count", err_count_a, 0);
        chk("midrst_ref_state", ref_state_a, 0);
        chk("midrst_count_b", err_count_b, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;

        // Randomized traffic: gaps, sparse corruption, error bursts, occasional clears
        for (int i = 0; i < 3000; i++) begin
            logic v, c, flip;
            v    = ($urandom_range(0, 3) != 0);
            c    = ($urandom_range(0, 63) == 0);
            flip = ((i / 200) % 3 == 2) ? ($urandom_range(0, 1) == 0)
                                        : ($urandom_range(0, 19) == 0);
            if (v) begin
                step(pbit(pos) ^ flip, 1'b1, c);
                pos++;
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
